// File: rtl/philo_bank.sv
`default_nettype none
// ============================================================================
// Module   : philo_bank
// Purpose  : Bank of dining-philosopher timing engines sharing one tagged,
//            round-robin arbitrated event FIFO.
// Revision : 1.0
// ============================================================================
module philo_bank #(
    parameter int N_PHILO    = 5,
    parameter int EAT_TIME   = 2,
    parameter int THINK_TIME = 5,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_W    = (N_PHILO > 1) ? $clog2(N_PHILO) : 1,
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1),
    localparam int TMR_MAX = (EAT_TIME > THINK_TIME) ? EAT_TIME : THINK_TIME,
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1,
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] may_eat,
    output logic [N_PHILO-1:0] hungry,
    output logic [N_PHILO-1:0] eating,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic               evt_kind,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               proto_err
);

    localparam logic [1:0]       c_think     = 2'd0;
    localparam logic [1:0]       c_hungry    = 2'd1;
    localparam logic [1:0]       c_eat       = 2'd2;
    localparam logic [TMR_W-1:0] c_eat_rld   = TMR_W'(EAT_TIME);
    localparam logic [TMR_W-1:0] c_think_rld = TMR_W'(THINK_TIME);
    localparam logic [LVL_W-1:0] c_full      = LVL_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]  c_last_id   = ID_W'(N_PHILO - 1);
    localparam logic [PTR_W-1:0] c_last_slot = PTR_W'(FIFO_DEPTH - 1);

    logic [1:0]       r_state     [N_PHILO];
    logic [1:0]       w_state_nxt [N_PHILO];
    logic [TMR_W-1:0] r_tmr       [N_PHILO];
    logic [TMR_W-1:0] w_tmr_nxt   [N_PHILO];

    logic [N_PHILO-1:0] w_req;
    logic [N_PHILO-1:0] w_gnt;
    logic               w_gnt_valid;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_gnt_kind;
    logic [ID_W-1:0]    w_scan_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               w_illegal;
    logic               r_proto_err;

    logic [ID_W:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_can_push;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] f_slot_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_slot) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < N_PHILO; gi++) begin : g_ch
        assign w_req[gi]  = ((r_state[gi] == c_think) || (r_state[gi] == c_eat)) &&
                            (r_tmr[gi] == '0);
        assign hungry[gi] = (r_state[gi] == c_hungry);
        assign eating[gi] = (r_state[gi] == c_eat);
    end

    assign w_can_push = (r_level < c_full);

    // Scan from highest offset down so the last hit is the first channel after the pointer.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = '0;
        w_scan_id   = '0;
        for (int k = N_PHILO; k >= 1; k--) begin
            w_scan_id = ID_W'((int'(r_rr_ptr) + k) % N_PHILO);
            if (w_can_push && w_req[w_scan_id]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = w_scan_id;
            end
        end
        w_gnt = '0;
        if (w_gnt_valid) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    assign w_gnt_kind = (r_state[w_gnt_id] == c_think);
    assign w_push     = w_gnt_valid;
    assign w_pop      = (r_level != '0) && evt_ready;

    always_comb begin
        w_illegal = 1'b0;
        for (int i = 0; i < N_PHILO; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tmr_nxt[i]   = r_tmr[i];
            case (r_state[i])
                c_think: begin
                    if (r_tmr[i] != '0) begin
                        w_tmr_nxt[i] = r_tmr[i] - TMR_W'(1);
                    end else if (w_gnt[i]) begin
                        w_state_nxt[i] = c_hungry;
                    end
                end
                c_hungry: begin
                    if (may_eat[i]) begin
                        w_state_nxt[i] = c_eat;
                        w_tmr_nxt[i]   = c_eat_rld;
                    end
                end
                c_eat: begin
                    if (r_tmr[i] != '0) begin
                        w_tmr_nxt[i] = r_tmr[i] - TMR_W'(1);
                    end else if (w_gnt[i]) begin
                        w_state_nxt[i] = c_think;
                        w_tmr_nxt[i]   = c_think_rld;
                    end
                end
                default: begin
                    w_state_nxt[i] = c_think;
                    w_tmr_nxt[i]   = c_think_rld;
                end
            endcase
            if (may_eat[i] && (r_state[i] != c_hungry)) begin
                w_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_PHILO; i++) begin
                r_state[i] <= c_think;
                r_tmr[i]   <= c_think_rld;
            end
            r_rr_ptr    <= c_last_id;
            r_proto_err <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            for (int i = 0; i < N_PHILO; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tmr[i]   <= w_tmr_nxt[i];
            end
            if (w_gnt_valid) begin
                r_rr_ptr <= w_gnt_id;
            end
            if (w_illegal) begin
                r_proto_err <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= f_slot_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_slot_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {w_gnt_id, w_gnt_kind};
        end
    end

    assign evt_valid            = (r_level != '0);
    assign {evt_id, evt_kind}   = evt_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level           = r_level;
    assign proto_err            = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_philo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_philo_bank
// Purpose  : Scoreboard bench for philo_bank against an eligibility-time model.
// Revision : 1.0
// ============================================================================
module tb_philo_bank;

    localparam int N     = 5;
    localparam int EAT   = 2;
    localparam int THINK = 5;
    localparam int DEPTH = 8;
    localparam int IDW   = 3;
    localparam int LVLW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    may_eat;
    logic [N-1:0]    hungry;
    logic [N-1:0]    eating;
    logic            evt_valid;
    logic            evt_ready;
    logic [IDW-1:0]  evt_id;
    logic            evt_kind;
    logic [LVLW-1:0] fifo_level;
    logic            proto_err;

    always #5 clk = ~clk;

    philo_bank #(
        .N_PHILO    (N),
        .EAT_TIME   (EAT),
        .THINK_TIME (THINK),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .may_eat    (may_eat),
        .hungry     (hungry),
        .eating     (eating),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_kind   (evt_kind),
        .fifo_level (fifo_level),
        .proto_err  (proto_err)
    );

    int n_vec   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit started = 1'b0;

    // Model: phase 0 thinking, 1 hungry, 2 eating; elig = first edge a request can win.
    int ph   [N];
    int elig [N];
    int m_ptr;
    int m_level;
    bit m_perr;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int  gid;
        bit  pop;
        gid = -1;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                ph[i]   = 0;
                elig[i] = cyc + THINK + 1;
            end
            m_ptr   = N - 1;
            m_level = 0;
            m_perr  = 1'b0;
            exp_q.delete();
        end else begin
            pop = evt_ready && (m_level > 0);
            if (m_level < DEPTH) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (gid < 0 && ph[c] != 1 && cyc >= elig[c]) gid = c;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (may_eat[i]) begin
                    if (ph[i] == 1) begin
                        ph[i]   = 2;
                        elig[i] = cyc + EAT + 1;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
            end
            if (gid >= 0) begin
                if (ph[gid] == 0) begin
                    ph[gid] = 1;
                    exp_q.push_back(gid * 2 + 1);
                end else begin
                    ph[gid]   = 0;
                    elig[gid] = cyc + THINK + 1;
                    exp_q.push_back(gid * 2);
                end
                m_ptr = gid;
                m_level++;
            end
            if (pop) m_level--;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        started = 1'b1;
    endtask

    function automatic logic [N-1:0] model_mask(input int p);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i] = (ph[i] == p);
        return m;
    endfunction

    // Monitor: compares visible state every cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        int e;
        if (started) begin
            chk("hungry", int'(hungry), int'(model_mask(1)));
            chk("eating", int'(eating), int'(model_mask(2)));
            chk("fifo_level", int'(fifo_level), m_level);
            chk("proto_err", int'(proto_err), int'(m_perr));
            chk("evt_valid", int'(evt_valid), int'(m_level > 0));
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", int'({evt_id, evt_kind}), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_id", int'(evt_id), e / 2);
                    chk("evt_kind", int'(evt_kind), e % 2);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_evt_valid"}, int'(evt_valid), 0);
        chk({tag, "_fifo_level"}, int'(fifo_level), 0);
        chk({tag, "_hungry"}, int'(hungry), 0);
        chk({tag, "_eating"}, int'(eating), 0);
        chk({tag, "_proto_err"}, int'(proto_err), 0);
        chk({tag, "_evt_id"}, int'(evt_id), 0);
        chk({tag, "_evt_kind"}, int'(evt_kind), 0);
    endtask

    // Edges 1..11 after a reset edge, consumer always ready.
    task automatic startup_run();
        evt_ready = 1'b1;
        may_eat   = '0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 5)  chk("hungry_after_edge5", int'(hungry), 0);
            if (e == 6)  chk("hungry_after_edge6", int'(hungry), 5'b00001);
            if (e == 10) chk("hungry_after_edge10", int'(hungry), 5'b11111);
        end
    endtask

    initial begin
        bit did_illegal;
        reset     = 1'b1;
        may_eat   = '0;
        evt_ready = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("reset");
        startup_run();

        // Backpressure: feed everyone, then hold the consumer off until the FIFO fills.
        evt_ready = 1'b0;
        may_eat   = model_mask(1);
        tick();
        may_eat     = '0;
        did_illegal = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!did_illegal && ph[3] == 0) begin
                may_eat[3] = 1'b1;
                tick();
                may_eat     = '0;
                did_illegal = 1'b1;
                chk("proto_err_set", int'(proto_err), 1);
            end else begin
                tick();
            end
        end
        chk("level_full", int'(fifo_level), DEPTH);
        chk("proto_err_sticky", int'(proto_err), 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("midreset");
        startup_run();

        // Randomized traffic with alternating heavy and light backpressure.
        for (int c = 0; c < 3000; c++) begin
            if (((c / 200) % 2) == 0) evt_ready = ($urandom_range(0, 3) != 0);
            else                      evt_ready = ($urandom_range(0, 7) == 0);
            may_eat = '0;
            for (int i = 0; i < N; i++) begin
                if (ph[i] == 1 && $urandom_range(0, 2) == 0) may_eat[i] = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) may_eat[$urandom_range(0, N - 1)] = 1'b1;
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset   = 1'b0;
        may_eat = '0;
        tick();
        chk("scoreboard_backlog", exp_q.size(), m_level);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
